trap_filter_mc: RTL and testbench
=================================

Name: trap_filter_mc

Overview:
- Parametrised next-generation trapezoidal (Jordanov-Knoll) shaper.
- Fixes over the first generation:
  - generic data and accumulator widths;
  - runtime-programmable K/L with validation;
  - delay lines advance only on accepted samples;
  - explicit fill/run state machine;
  - fixed-point decay coefficient;
  - saturated output with a proper valid pulse.
- Sits between the ADC sample stream and the pulse-height/histogram logic.

Parameters:
- IN_W, 16: signed input sample width.
- OUT_W, 32: signed output width.
- ACC_W, 48: internal accumulator width.
- DEPTH_LOG2, 12: delay-line depth is 2^DEPTH_LOG2; maximum K and L is 2^DEPTH_LOG2-1.
- M_W, 18: signed decay-coefficient width.
- M_FRAC, 0: number of fractional bits in m_coef.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  IN_W  signed sample.
- s_axis_tvalid  in  1  sample strobe. No backpressure.
- cfg_k  in  DEPTH_LOG2  rise length K.
- cfg_l  in  DEPTH_LOG2  L; flat top is L-K.
- m_coef  in  M_W  signed decay factor M, fixed point with M_FRAC fractional bits.
- cfg_load  in  1  one-cycle pulse; latches cfg_k, cfg_l, m_coef.
- cfg_err  out  1  sticky; set when a load is rejected.
- running  out  1  high in RUN.
- m_axis_tdata  out  OUT_W  signed filter output.
- m_axis_tvalid  out  1  output strobe.

Behaviour:
- Reset:
  - All pipeline registers, accumulators, pointers, counters, cfg_err, running, m_axis_tdata and m_axis_tvalid are cleared to 0.
  - Active config resets to K=0, L=0, M=0. State is IDLE.
  - Reset mid-operation discards everything, including delay-line contents; a later fill re-zeroes them logically.
- cfg_load:
  - Accepted only if 1 <= cfg_k <= cfg_l.
  - On accept: latch K/L/M, clear accumulators and fill counter, go to FILL. Honoured in any state.
  - On reject: set cfg_err, keep the old config and state.
  - cfg_load has priority over a same-cycle sample; that sample is dropped.
- States:
  - IDLE: samples are ignored, no output.
  - FILL: on each accepted sample, fill_cnt increments. Go to RUN when fill_cnt reaches K+L.
  - RUN: continuous operation.
- Delay lines:
  - Two circular single-port-write RAMs, 2^DEPTH_LOG2 deep, sharing one write pointer that increments per accepted sample (wraps mod depth).
  - Read address = wr_ptr - K (line X) and wr_ptr - L (line D1), modular.
  - Reads of entries not written since the last load return 0, controlled by fill_cnt.
- Arithmetic, per accepted sample n:
  - d1 = x(n) - x(n-K), IN_W+1 bits. Forced to 0 while fill_cnt < K. Written to line D1.
  - d2 = d1(n) - d1(n-L), IN_W+2 bits.
  - p = p + d2, in ACC_W bits.
  - r = r + (p << M_FRAC) + M*d2, in ACC_W bits.
  - p and r are held at 0 until fill_cnt >= K+L.
  - Accumulators wrap, two's complement.
- Output:
  - y = r >>> M_FRAC, saturated to OUT_W (clamp to max or min).
  - m_axis_tvalid pulses once per accepted sample in RUN.
  - Fixed latency: 5 clk from the s_axis_tvalid cycle to the m_axis_tvalid cycle.
  - Pipeline tags propagate every clock; accumulators update only on tagged cycles.
- Back-to-back valids every clock are fully supported. Gaps in tvalid stretch time only in samples, not clocks.
- K=L is legal (triangle). K=L=2^DEPTH_LOG2-1 is legal (full-depth wrap).

Optional Feature:
- Macro: TRAP_PEAK_EN.
- With the macro defined, added ports:
  - peak_thr  in  OUT_W
  - m_peak_tdata  out  OUT_W
  - m_peak_tvalid  out  1
- Peak capture behaviour:
  - Tracks the maximum y while y > peak_thr.
  - On the first output with y <= peak_thr, m_peak_tdata is set to that maximum and m_peak_tvalid pulses for 1 clk, on the cycle after that output.
  - Reset clears the tracker, m_peak_tdata and m_peak_tvalid; cfg_load clears the tracker.
- Without the macro: these ports and the tracker logic do not exist.

Test Plan:
- Baseline: K=4, L=8, M=0; constant input 1000 for 100 samples.
  - -> first m_axis_tvalid on the 13th sample + 5 clk; every output 0.
- Impulse: K=4, L=10, M=0, zero baseline; single sample 100 at n0 after RUN.
  - -> y = 100, 200, 300, 400 at n0..n0+3;
  - -> 400 through n0+9;
  - -> 300, 200, 100, 0 at n0+10..n0+13; 0 thereafter.
- Gapped valid: repeat the impulse with tvalid every 3rd clk.
  - -> identical output sequence per sample; each output 5 clk after its input.
- Config: cfg_load with K=6, L=5.
  - -> cfg_err=1, running stays 1, old K/L stay in effect.
  - Then K=6, L=6 -> FILL for 12 samples, running=1 after.
- Saturation: OUT_W=16, K=L=1, M=32767, one sample 32767.
  - -> y clamps at 32767, never wraps negative.
- Reset mid-impulse: assert aresetn=0 for 1 clk at n0+5.
  - -> all outputs 0 next clk, state IDLE; after cfg_load, refill yields 0 output on zero input.
  - With TRAP_PEAK_EN, a rerun of the impulse with peak_thr=50 gives one m_peak_tvalid with m_peak_tdata=400.

Source files
------------

// File: rtl/trap_filter_mc.sv
// Trapezoidal (Jordanov-Knoll) shaper: runtime K/L/M, delay lines that advance only on accepted samples, saturated output.
// Optional peak capture on the output stream is compiled in with TRAP_PEAK_EN.
module trap_filter_mc #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 32,
  parameter int ACC_W      = 48,
  parameter int DEPTH_LOG2 = 12,
  parameter int M_W        = 18,
  parameter int M_FRAC     = 0
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic [DEPTH_LOG2-1:0] cfg_k,
  input  logic [DEPTH_LOG2-1:0] cfg_l,
  input  logic [M_W-1:0]        m_coef,
  input  logic                  cfg_load,
  output logic                  cfg_err,
  output logic                  running,
  output logic [OUT_W-1:0]      m_axis_tdata,
  output logic                  m_axis_tvalid
`ifdef TRAP_PEAK_EN
  ,
  input  logic [OUT_W-1:0]      peak_thr,
  output logic [OUT_W-1:0]      m_peak_tdata,
  output logic                  m_peak_tvalid
`endif
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CW     = DEPTH_LOG2 + 1;
  localparam int STAGES = 3;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   k_act, l_act, wr_ptr, ptr1, rd_x, rd_d;
  logic signed [M_W-1:0]   m_act;
  logic [CW-1:0]           fill_cnt, fill_nxt, kl_sum;
  logic                    cfg_ok, load_acc, acc_in;

  assign cfg_ok   = (cfg_k != '0) && (cfg_k <= cfg_l);
  assign load_acc = cfg_load && cfg_ok;
  assign acc_in   = s_axis_tvalid && !cfg_load && (state != IDLE);
  assign kl_sum   = {1'b0, k_act} + {1'b0, l_act};
  assign fill_nxt = fill_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state    <= IDLE;
      running  <= 1'b0;
      cfg_err  <= 1'b0;
      k_act    <= '0;
      l_act    <= '0;
      m_act    <= '0;
      fill_cnt <= '0;
      wr_ptr   <= '0;
    end else if (cfg_load) begin
      if (cfg_ok) begin
        k_act    <= cfg_k;
        l_act    <= cfg_l;
        m_act    <= $signed(m_coef);
        fill_cnt <= '0;
        state    <= FILL;
        running  <= 1'b0;
      end else begin
        cfg_err  <= 1'b1;
      end
    end else if (acc_in) begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (state == FILL) begin
        fill_cnt <= fill_nxt;
        if (fill_nxt == kl_sum) begin
          state   <= RUN;
          running <= 1'b1;
        end
      end
    end
  end

  // Delay lines: no reset; stale entries are masked by the fill flags.
  logic [IN_W-1:0] ram_x [DEPTH];
  logic [IN_W:0]   ram_d [DEPTH];
  logic [IN_W-1:0] xk_rd;
  logic [IN_W:0]   dl_rd;
  logic            wr1;
  logic signed [IN_W:0] d1;

  assign rd_x = wr_ptr - k_act;
  assign rd_d = ptr1 - l_act;

  always_ff @(posedge clk) begin
    if (acc_in) ram_x[wr_ptr] <= s_axis_tdata;
    xk_rd <= ram_x[rd_x];
  end

  always_ff @(posedge clk) begin
    if (wr1) ram_d[ptr1] <= d1;
    dl_rd <= ram_d[rd_d];
  end

  // vld_pipe tags samples accepted in RUN, i.e. those that will produce an output.
  logic [STAGES:0]          vld_pipe;
  logic [IN_W-1:0]          x1;
  logic                     kv1, lv1, lv2;
  logic signed [IN_W:0]     d1_2;
  logic [IN_W:0]            dl_sel;
  logic signed [IN_W+1:0]   d2, d2_3;
  logic signed [ACC_W-1:0]  md2_3, p_acc, r_acc, p_nxt, r_nxt, y_full;
  logic [ACC_W-OUT_W:0]     y_hi;
  logic [OUT_W-1:0]         y_sat;

  assign d1     = kv1 ? ($signed({x1[IN_W-1], x1}) - $signed({xk_rd[IN_W-1], xk_rd})) : '0;
  assign dl_sel = lv2 ? dl_rd : '0;
  assign d2     = $signed({d1_2[IN_W], d1_2}) - $signed({dl_sel[IN_W], dl_sel});
  assign p_nxt  = p_acc + ACC_W'(d2_3);
  assign r_nxt  = r_acc + (p_nxt <<< M_FRAC) + md2_3;
  assign y_full = r_acc >>> M_FRAC;
  assign y_hi   = y_full[ACC_W-1:OUT_W-1];

  always_comb begin
    y_sat = y_full[OUT_W-1:0];
    if (!(&y_hi) && (|y_hi))
      y_sat = y_full[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_pipe      <= '0;
      wr1           <= 1'b0;
      x1            <= '0;
      ptr1          <= '0;
      kv1           <= 1'b0;
      lv1           <= 1'b0;
      d1_2          <= '0;
      lv2           <= 1'b0;
      d2_3          <= '0;
      md2_3         <= '0;
      p_acc         <= '0;
      r_acc         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      vld_pipe <= load_acc ? '0 : {vld_pipe[STAGES-1:0], acc_in && (state == RUN)};
      wr1      <= acc_in;
      x1       <= s_axis_tdata;
      ptr1     <= wr_ptr;
      kv1      <= fill_cnt >= {1'b0, k_act};
      lv1      <= fill_cnt >= {1'b0, l_act};
      d1_2     <= d1;
      lv2      <= lv1;
      d2_3     <= d2;
      md2_3    <= ACC_W'(d2) * ACC_W'(m_act);
      if (load_acc) begin
        p_acc <= '0;
        r_acc <= '0;
      end else if (vld_pipe[2]) begin
        p_acc <= p_nxt;
        r_acc <= r_nxt;
      end
      m_axis_tvalid <= vld_pipe[3];
      if (vld_pipe[3]) m_axis_tdata <= y_sat;
    end
  end

`ifdef TRAP_PEAK_EN
  logic                    trk_act;
  logic signed [OUT_W-1:0] trk_max;

  // Peak is reported the cycle after the first output that falls back to the threshold.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      trk_act       <= 1'b0;
      trk_max       <= '0;
      m_peak_tdata  <= '0;
      m_peak_tvalid <= 1'b0;
    end else begin
      m_peak_tvalid <= 1'b0;
      if (load_acc) begin
        trk_act <= 1'b0;
      end else if (m_axis_tvalid) begin
        if ($signed(m_axis_tdata) > $signed(peak_thr)) begin
          trk_act <= 1'b1;
          if (!trk_act || ($signed(m_axis_tdata) > trk_max)) trk_max <= $signed(m_axis_tdata);
        end else if (trk_act) begin
          trk_act       <= 1'b0;
          m_peak_tdata  <= trk_max;
          m_peak_tvalid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_trap_filter_mc.sv
// Randomized bench for trap_filter_mc against a sample-indexed reference of the shaper equations.
module tb_trap_filter_mc;
  localparam int IN_W = 16, OUT_W = 32, ACC_W = 48, DL = 6, M_W = 18, MF = 0;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [IN_W-1:0]      s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic [DL-1:0]        cfg_k = '0, cfg_l = '0;
  logic [M_W-1:0]       m_coef = '0;
  logic                 cfg_load = 1'b0;
  logic                 cfg_err, running, m_axis_tvalid;
  logic [OUT_W-1:0]     m_axis_tdata;
`ifdef TRAP_PEAK_EN
  logic [OUT_W-1:0]     peak_thr = 50;
  logic [OUT_W-1:0]     m_peak_tdata;
  logic                 m_peak_tvalid;
`endif

  trap_filter_mc #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .DEPTH_LOG2(DL),
                   .M_W(M_W), .M_FRAC(MF)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .m_coef(m_coef), .cfg_load(cfg_load),
    .cfg_err(cfg_err), .running(running),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid)
`ifdef TRAP_PEAK_EN
    , .peak_thr(peak_thr), .m_peak_tdata(m_peak_tdata), .m_peak_tvalid(m_peak_tvalid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_bad = 0;
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: whole-history arrays indexed by sample number since the last load.
  typedef enum {M_IDLE, M_FILL, M_RUN} mst_t;
  typedef struct { longint y; int c; } exp_t;
  mst_t   mst;
  bit     me;
  int     mk, ml;
  longint mm, p, r;
  int     xh[$];
  int     dh[$];
  exp_t   eq[$];
  bit     mon_en = 1'b0;

  function automatic longint wrap(input longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  task automatic model_smp(input int x);
    int n, d1, d2;
    exp_t e;
    if (mst == M_IDLE) return;
    n  = xh.size();
    xh.push_back(x);
    d1 = (n < mk) ? 0 : x - xh[n - mk];
    dh.push_back(d1);
    d2 = d1 - ((n < ml) ? 0 : dh[n - ml]);
    if (n >= mk + ml) begin
      p   = wrap(p + d2);
      r   = wrap(r + (p <<< MF) + mm * d2);
      e.y = sat(r >>> MF);
      e.c = cyc + 5;
      eq.push_back(e);
    end
    if (mst == M_FILL && n + 1 == mk + ml) mst = M_RUN;
  endtask

  task automatic smp(input bit v, input int x);
    s_axis_tvalid = v;
    s_axis_tdata  = x[IN_W-1:0];
    if (v) model_smp(x);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic load(input int k, input int l, input longint m);
    logic [63:0] mv;
    int junk;
    mv = m;
    junk = rnd16();
    cfg_k = k[DL-1:0];
    cfg_l = l[DL-1:0];
    m_coef = mv[M_W-1:0];
    cfg_load = 1'b1;
    s_axis_tvalid = ($urandom_range(1, 0) == 1);
    s_axis_tdata  = junk[IN_W-1:0];
    if (k >= 1 && k <= l) begin
      mk = k; ml = l; mm = m; mst = M_FILL;
      xh.delete(); dh.delete(); p = 0; r = 0;
    end else begin
      me = 1'b1;
    end
    @(posedge clk); #1;
    cfg_load = 1'b0;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) smp(1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (eq.size() > 0 && eq[0].c == cyc) begin
        chk("out_vld", m_axis_tvalid, 1);
        chk("out_y", $signed(m_axis_tdata), eq[0].y);
        void'(eq.pop_front());
      end else begin
        chk("idle_vld", m_axis_tvalid, 0);
      end
    end
  end

  initial begin
    int k, l, ns;
    longint m;
    mst = M_IDLE; me = 1'b0; mk = 0; ml = 0; mm = 0; p = 0; r = 0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    chk("rst_err", cfg_err, 0);
    chk("rst_run", running, 0);
    chk("rst_vld", m_axis_tvalid, 0);
    chk("rst_data", $signed(m_axis_tdata), 0);
    mon_en = 1'b1;

    repeat (10) smp(1'b1, rnd16());
    chk("idle_run", running, 0);

    load(4, 8, 0);
    chk("base_fill", running, 0);
    repeat (100) smp(1'b1, 1000);
    drain();
    chk("base_run", running, 1);

    load(4, 10, 0);
    repeat (20) smp(1'b1, 0);
    smp(1'b1, 100);
    repeat (20) smp(1'b1, 0);
    drain();

    load(4, 10, 0);
    repeat (20) begin smp(1'b1, 0); smp(1'b0, 0); smp(1'b0, 0); end
    smp(1'b1, 100); smp(1'b0, 0); smp(1'b0, 0);
    repeat (20) begin smp(1'b1, 0); smp(1'b0, 0); smp(1'b0, 0); end
    drain();

    load(6, 5, 1234);
    chk("rej_err", cfg_err, 1);
    chk("rej_run", running, 1);
    repeat (30) smp(1'b1, rnd16());
    drain();
    load(6, 6, 0);
    chk("k6_fill", running, 0);
    repeat (11) smp(1'b1, rnd16());
    chk("k6_fill11", running, 0);
    smp(1'b1, rnd16());
    chk("k6_run", running, 1);
    repeat (20) smp(1'b1, rnd16());
    drain();

    load(1, 1, 131071);
    repeat (5) smp(1'b1, 0);
    smp(1'b1, 32767);
    repeat (5) smp(1'b1, 0);
    smp(1'b1, -32768);
    repeat (5) smp(1'b1, 0);
    drain();

    load(63, 63, longint'($urandom_range(262143, 0)) - 131072);
    repeat (300) smp($urandom_range(3, 0) != 0, rnd16());
    drain();

    repeat (6) begin
      k = $urandom_range(63, 1);
      l = $urandom_range(63, k);
      m = longint'($urandom_range(262143, 0)) - 131072;
      load(k, l, m);
      ns = k + l + 80;
      repeat (ns) smp($urandom_range(2, 0) != 0, rnd16());
      drain();
    end

    load(4, 10, 0);
    repeat (16) smp(1'b1, 0);
    smp(1'b1, 100);
    repeat (5) smp(1'b1, 0);
    aresetn = 1'b0;
    while (eq.size() > 0 && eq[$].c > cyc) void'(eq.pop_back());
    mst = M_IDLE; me = 1'b0; mk = 0; ml = 0; mm = 0; p = 0; r = 0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    chk("mid_data", $signed(m_axis_tdata), 0);
    chk("mid_vld", m_axis_tvalid, 0);
    chk("mid_run", running, 0);
    chk("mid_err", cfg_err, 0);
    repeat (5) smp(1'b1, rnd16());
    load(0, 3, 0);
    chk("k0_err", cfg_err, 1);
    chk("k0_run", running, 0);
    load(4, 10, 0);
    repeat (40) smp(1'b1, 0);
    drain();
    chk("refill_run", running, 1);

    chk("eq_empty", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
